// File: rtl/score_digit_ctrl.sv
// score_digit_ctrl: two-player BCD score keeper with a 2-stage glyph overlay
// pipeline and a PLAY/OVER game FSM.
// Optional feature macro: SCORE_BLINK_EN. When it is defined, the winner's
// digits blink in OVER state (16 frames on, 16 frames off).
// game_over is the registered mirror of the FSM state (high in OVER) and serves
// as its observation point.
module score_digit_ctrl #(
  parameter int         CELL_SHIFT = 3,
  parameter logic [9:0] SCORE_Y    = 10'd16,
  parameter logic [9:0] P1_X       = 10'd192,
  parameter logic [9:0] P2_X       = 10'd400,
  parameter logic [6:0] WIN_SCORE  = 7'd11
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       video_on,
  input  logic       frame_tick,
  input  logic       point_p1,
  input  logic       point_p2,
  input  logic       restart,
  input  logic       glyph_pixel,
  output logic [4:0] glyph_number,
  output logic [4:0] glyph_position,
  output logic       score_pixel,
  output logic       game_over,
  output logic [1:0] winner
);

  // Ones field sits one glyph (3 cells) plus one blank cell right of tens.
  localparam logic [9:0] ONES_OFS  = 10'(4 << CELL_SHIFT);
  localparam logic [9:0] P1_ONES_X = P1_X + ONES_OFS;
  localparam logic [9:0] P2_ONES_X = P2_X + ONES_OFS;

  typedef enum logic {S_PLAY = 1'b0, S_OVER = 1'b1} state_t;

  state_t     state;
  logic [7:0] p1_score;  // {tens, ones} BCD
  logic [7:0] p2_score;

  // BCD increment with decimal carry, saturating at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)
      return v;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] bcd_to_bin(input logic [7:0] v);
    return ({3'b000, v[7:4]} * 7'd10) + {3'b000, v[3:0]};
  endfunction

  logic [7:0] p1_nxt, p2_nxt;
  logic       p1_win, p2_win;

  // Post-update scores and win detection for the PLAY state.
  always_comb begin
    p1_nxt = point_p1 ? bcd_inc(p1_score) : p1_score;
    p2_nxt = point_p2 ? bcd_inc(p2_score) : p2_score;
    p1_win = (bcd_to_bin(p1_nxt) >= WIN_SCORE);
    p2_win = (bcd_to_bin(p2_nxt) >= WIN_SCORE);
  end

`ifdef SCORE_BLINK_EN
  logic [4:0] blink_cnt;
`endif

  // Game FSM: scores, state, winner; restart beats simultaneous points.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_PLAY;
      p1_score  <= 8'h00;
      p2_score  <= 8'h00;
      game_over <= 1'b0;
      winner    <= 2'b00;
`ifdef SCORE_BLINK_EN
      blink_cnt <= 5'd0;
`endif
    end else if (restart) begin
      state     <= S_PLAY;
      p1_score  <= 8'h00;
      p2_score  <= 8'h00;
      game_over <= 1'b0;
      winner    <= 2'b00;
    end else begin
      case (state)
        S_PLAY: begin
          p1_score <= p1_nxt;
          p2_score <= p2_nxt;
          if (p1_win || p2_win) begin
            state     <= S_OVER;
            game_over <= 1'b1;
            winner    <= {p2_win, p1_win};
`ifdef SCORE_BLINK_EN
            blink_cnt <= 5'd0;
`endif
          end
        end
        S_OVER: begin
          // Point pulses are ignored until restart.
`ifdef SCORE_BLINK_EN
          if (frame_tick)
            blink_cnt <= blink_cnt + 5'd1;
`endif
        end
        default: state <= S_PLAY;
      endcase
    end
  end

  // Field hit test: unsigned subtraction makes pixels left/above wrap to a miss.
  logic [9:0] dy, row;
  logic [9:0] dx_p1t, dx_p1o, dx_p2t, dx_p2o;
  logic [9:0] c_p1t, c_p1o, c_p2t, c_p2o;
  logic       row_ok;
  logic       hit_c;
  logic [3:0] digit_c;
  logic [1:0] col_c;
  logic [1:0] owner_c;  // {player2, player1} field owner
  logic [4:0] num_c, pos_c;

  // Stage-1 combinational selection of digit and glyph bit index.
  always_comb begin
    dy      = pixel_y - SCORE_Y;
    row     = dy >> CELL_SHIFT;
    dx_p1t  = pixel_x - P1_X;
    dx_p1o  = pixel_x - P1_ONES_X;
    dx_p2t  = pixel_x - P2_X;
    dx_p2o  = pixel_x - P2_ONES_X;
    c_p1t   = dx_p1t >> CELL_SHIFT;
    c_p1o   = dx_p1o >> CELL_SHIFT;
    c_p2t   = dx_p2t >> CELL_SHIFT;
    c_p2o   = dx_p2o >> CELL_SHIFT;
    row_ok  = video_on && (row < 10'd5);
    hit_c   = 1'b0;
    digit_c = 4'd0;
    col_c   = 2'd0;
    owner_c = 2'b00;
    if (row_ok) begin
      if (c_p1t < 10'd3) begin
        hit_c = 1'b1; digit_c = p1_score[7:4]; col_c = c_p1t[1:0]; owner_c = 2'b01;
      end else if (c_p1o < 10'd3) begin
        hit_c = 1'b1; digit_c = p1_score[3:0]; col_c = c_p1o[1:0]; owner_c = 2'b01;
      end else if (c_p2t < 10'd3) begin
        hit_c = 1'b1; digit_c = p2_score[7:4]; col_c = c_p2t[1:0]; owner_c = 2'b10;
      end else if (c_p2o < 10'd3) begin
        hit_c = 1'b1; digit_c = p2_score[3:0]; col_c = c_p2o[1:0]; owner_c = 2'b10;
      end
    end
    if (hit_c) begin
      num_c = {1'b0, digit_c};
      pos_c = ({2'b00, row[2:0]} * 5'd3) + {3'b000, col_c};
    end else begin
      num_c = 5'd15;
      pos_c = 5'd0;
    end
  end

  logic hit_q;

  // Stage 1 registers: glyph lookup address and hit flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      glyph_number   <= 5'd15;
      glyph_position <= 5'd0;
      hit_q          <= 1'b0;
    end else begin
      glyph_number   <= num_c;
      glyph_position <= pos_c;
      hit_q          <= hit_c;
    end
  end

  logic blink_visible;

`ifdef SCORE_BLINK_EN
  logic [1:0] owner_q;

  // Stage 1 companion: remember which player's field was addressed.
  always_ff @(posedge clk) begin
    if (!reset_n)
      owner_q <= 2'b00;
    else
      owner_q <= owner_c;
  end

  // Winner's fields (both on a tie) go dark while counter bit 4 is set.
  assign blink_visible = !((state == S_OVER) && blink_cnt[4] && |(owner_q & winner));
`else
  assign blink_visible = 1'b1;

  // frame_tick and field ownership only matter for blinking.
  logic unused_blink;
  assign unused_blink = ^{frame_tick, owner_c};
`endif

  // Stage 2: gate the returned glyph bit with the stage-1 hit.
  always_ff @(posedge clk) begin
    if (!reset_n)
      score_pixel <= 1'b0;
    else
      score_pixel <= glyph_pixel & hit_q & blink_visible;
  end

endmodule

// File: tb/tb_score_digit_ctrl.sv
// tb_score_digit_ctrl: directed bench for score_digit_ctrl with default parameters.
module tb_score_digit_ctrl;

  localparam logic [9:0] SY  = 10'd16;
  localparam logic [9:0] P1X = 10'd192;
  localparam logic [9:0] P2X = 10'd400;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] pixel_x, pixel_y;
  logic       video_on, frame_tick, point_p1, point_p2, restart, glyph_pixel;
  logic [4:0] glyph_number, glyph_position;
  logic       score_pixel, game_over;
  logic [1:0] winner;

  int total = 0;
  int bad   = 0;

  score_digit_ctrl #(
    .CELL_SHIFT(3), .SCORE_Y(SY), .P1_X(P1X), .P2_X(P2X), .WIN_SCORE(7'd11)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .frame_tick(frame_tick), .point_p1(point_p1),
    .point_p2(point_p2), .restart(restart), .glyph_pixel(glyph_pixel),
    .glyph_number(glyph_number), .glyph_position(glyph_position),
    .score_pixel(score_pixel), .game_over(game_over), .winner(winner)
  );

  // clock
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic a, input logic b, input logic r);
    point_p1 = a; point_p2 = b; restart = r;
    tick();
    point_p1 = 1'b0; point_p2 = 1'b0; restart = 1'b0;
  endtask

  task automatic read_digit(input logic [9:0] x, output logic [4:0] num);
    pixel_x = x; pixel_y = SY;
    tick();
    num = glyph_number;
    pixel_x = 10'd0; pixel_y = 10'd0;
  endtask

  // Reads all four displayed digits as {p1t, p1o, p2t, p2o}, 5 bits each.
  task automatic read_scores(output logic [19:0] s);
    logic [4:0] n;
    read_digit(P1X, n);          s[19:15] = n;
    read_digit(P1X + 10'd32, n); s[14:10] = n;
    read_digit(P2X, n);          s[9:5]   = n;
    read_digit(P2X + 10'd32, n); s[4:0]   = n;
  endtask

  function automatic logic [19:0] sc(input logic [15:0] bcd);
    return {1'b0, bcd[15:12], 1'b0, bcd[11:8], 1'b0, bcd[7:4], 1'b0, bcd[3:0]};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [19:0] s;
    reset_n = 1'b0; point_p1 = 1'b1; point_p2 = 1'b1;
    pixel_x = P1X + 10'd8; pixel_y = SY; glyph_pixel = 1'b1;
    repeat (3) tick();
    total++; if (glyph_number !== 5'd15) begin bad++; $display("FAIL reset_glyph_number got=%0d exp=15", glyph_number); end
    total++; if (glyph_position !== 5'd0) begin bad++; $display("FAIL reset_glyph_position got=%0d exp=0", glyph_position); end
    total++; if (score_pixel !== 1'b0) begin bad++; $display("FAIL reset_score_pixel got=%b exp=0", score_pixel); end
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL reset_game_over got=%b exp=0", game_over); end
    total++; if (winner !== 2'b00) begin bad++; $display("FAIL reset_winner got=%b exp=00", winner); end
    reset_n = 1'b1; point_p1 = 1'b0; point_p2 = 1'b0;
    pixel_x = 10'd0; pixel_y = 10'd0; glyph_pixel = 1'b0;
    read_scores(s);
    total++; if (s !== sc(16'h0000)) begin bad++; $display("FAIL reset_scores got=%h exp=%h", s, sc(16'h0000)); end
  endtask

  task automatic test_p1_ten();
    logic [19:0] s;
    repeat (10) pulse(1'b1, 1'b0, 1'b0);
    read_scores(s);
    total++; if (s !== sc(16'h1000)) begin bad++; $display("FAIL p1_ten_scores got=%h exp=%h", s, sc(16'h1000)); end
    tick();  // flush the last hit out of stage 1
    pixel_x = P1X + 10'd8; pixel_y = SY; glyph_pixel = 1'b1;
    tick();
    total++; if (glyph_number !== 5'd1) begin bad++; $display("FAIL p1_ten_number got=%0d exp=1", glyph_number); end
    total++; if (glyph_position !== 5'd1) begin bad++; $display("FAIL p1_ten_position got=%0d exp=1", glyph_position); end
    total++; if (score_pixel !== 1'b0) begin bad++; $display("FAIL latency_n1_pixel got=%b exp=0", score_pixel); end
    pixel_x = 10'd0; pixel_y = 10'd0;
    tick();
    total++; if (score_pixel !== 1'b1) begin bad++; $display("FAIL latency_n2_pixel got=%b exp=1", score_pixel); end
    tick();
    total++; if (score_pixel !== 1'b0) begin bad++; $display("FAIL miss_gates_pixel got=%b exp=0", score_pixel); end
    // bottom-right cell of P1 ones field: row 4, col 2
    pixel_x = P1X + 10'd48; pixel_y = SY + 10'd32; glyph_pixel = 1'b0;
    tick();
    total++; if (glyph_position !== 5'd14) begin bad++; $display("FAIL corner_position got=%0d exp=14", glyph_position); end
    total++; if (glyph_number !== 5'd0) begin bad++; $display("FAIL corner_number got=%0d exp=0", glyph_number); end
    tick();
    total++; if (score_pixel !== 1'b0) begin bad++; $display("FAIL glyph_zero_pixel got=%b exp=0", score_pixel); end
    // gap column between tens and ones
    pixel_x = P1X + 10'd24; pixel_y = SY;
    tick();
    total++; if (glyph_number !== 5'd15) begin bad++; $display("FAIL gap_col_number got=%0d exp=15", glyph_number); end
    // row 5 just below the fields
    pixel_x = P1X; pixel_y = SY + 10'd40;
    tick();
    total++; if (glyph_number !== 5'd15) begin bad++; $display("FAIL row5_number got=%0d exp=15", glyph_number); end
    // line above SCORE_Y underflows
    pixel_x = P1X; pixel_y = SY - 10'd1;
    tick();
    total++; if (glyph_number !== 5'd15) begin bad++; $display("FAIL above_number got=%0d exp=15", glyph_number); end
    pixel_x = 10'd0; pixel_y = 10'd0;
  endtask

  task automatic test_simultaneous();
    logic [19:0] s;
    pulse(1'b0, 1'b0, 1'b1);
    repeat (9) pulse(1'b1, 1'b1, 1'b0);
    read_scores(s);
    total++; if (s !== sc(16'h0909)) begin bad++; $display("FAIL sim_0909 got=%h exp=%h", s, sc(16'h0909)); end
    pulse(1'b1, 1'b1, 1'b0);
    read_scores(s);
    total++; if (s !== sc(16'h1010)) begin bad++; $display("FAIL sim_1010 got=%h exp=%h", s, sc(16'h1010)); end
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL sim_game_over got=%b exp=0", game_over); end
  endtask

  task automatic test_p2_win();
    logic [19:0] s;
    pulse(1'b0, 1'b1, 1'b0);
    total++; if (game_over !== 1'b1) begin bad++; $display("FAIL p2win_game_over got=%b exp=1", game_over); end
    total++; if (winner !== 2'b10) begin bad++; $display("FAIL p2win_winner got=%b exp=10", winner); end
    pulse(1'b1, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    read_scores(s);
    total++; if (s !== sc(16'h1011)) begin bad++; $display("FAIL over_frozen got=%h exp=%h", s, sc(16'h1011)); end
    total++; if (winner !== 2'b10) begin bad++; $display("FAIL over_winner_held got=%b exp=10", winner); end
    // winner field still drawn (no frame ticks, so no blink phase)
    tick();
    pixel_x = P2X; pixel_y = SY; glyph_pixel = 1'b1;
    tick();
    pixel_x = 10'd0; pixel_y = 10'd0;
    tick();
    total++; if (score_pixel !== 1'b1) begin bad++; $display("FAIL over_pixel got=%b exp=1", score_pixel); end
    glyph_pixel = 1'b0;
  endtask

  task automatic test_tie();
    logic [19:0] s;
    pulse(1'b0, 1'b0, 1'b1);
    repeat (11) pulse(1'b1, 1'b1, 1'b0);
    total++; if (winner !== 2'b11) begin bad++; $display("FAIL tie_winner got=%b exp=11", winner); end
    total++; if (game_over !== 1'b1) begin bad++; $display("FAIL tie_game_over got=%b exp=1", game_over); end
    read_scores(s);
    total++; if (s !== sc(16'h1111)) begin bad++; $display("FAIL tie_scores got=%h exp=%h", s, sc(16'h1111)); end
  endtask

  task automatic test_restart_priority();
    logic [19:0] s;
    pulse(1'b1, 1'b0, 1'b1);
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL restart_game_over got=%b exp=0", game_over); end
    total++; if (winner !== 2'b00) begin bad++; $display("FAIL restart_winner got=%b exp=00", winner); end
    read_scores(s);
    total++; if (s !== sc(16'h0000)) begin bad++; $display("FAIL restart_scores got=%h exp=%h", s, sc(16'h0000)); end
    pulse(1'b1, 1'b0, 1'b0);
    read_scores(s);
    total++; if (s !== sc(16'h0100)) begin bad++; $display("FAIL play_after_restart got=%h exp=%h", s, sc(16'h0100)); end
    repeat (10) pulse(1'b1, 1'b0, 1'b0);
    total++; if (winner !== 2'b01) begin bad++; $display("FAIL p1win_winner got=%b exp=01", winner); end
    pulse(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_miss();
    video_on = 1'b0; pixel_x = P1X; pixel_y = SY; glyph_pixel = 1'b1;
    tick();
    total++; if (glyph_number !== 5'd15) begin bad++; $display("FAIL video_off_number got=%0d exp=15", glyph_number); end
    total++; if (glyph_position !== 5'd0) begin bad++; $display("FAIL video_off_position got=%0d exp=0", glyph_position); end
    tick();
    total++; if (score_pixel !== 1'b0) begin bad++; $display("FAIL video_off_pixel got=%b exp=0", score_pixel); end
    video_on = 1'b1; pixel_x = 10'd0; pixel_y = 10'd0;
    tick();
    total++; if (glyph_number !== 5'd15) begin bad++; $display("FAIL origin_number got=%0d exp=15", glyph_number); end
    tick();
    total++; if (score_pixel !== 1'b0) begin bad++; $display("FAIL origin_pixel got=%b exp=0", score_pixel); end
    glyph_pixel = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset_n = 1'b0; pixel_x = 10'd0; pixel_y = 10'd0; video_on = 1'b1;
    frame_tick = 1'b0; point_p1 = 1'b0; point_p2 = 1'b0; restart = 1'b0;
    glyph_pixel = 1'b0;
    test_reset();
    test_p1_ten();
    test_simultaneous();
    test_p2_win();
    test_tie();
    test_restart_priority();
    test_miss();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_digit_ctrl.md
SCORE_DIGIT_CTRL -- requirements
Module: score_digit_ctrl

Interface
REQ-001 SHALL have parameter CELL_SHIFT, default 3, meaning log2 of glyph cell size in pixels (cell = 8x8 px).
REQ-002 SHALL have parameter SCORE_Y, default 10'd16, meaning top line of all score fields.
REQ-003 SHALL have parameter P1_X, default 10'd192, meaning left pixel of player-1 tens field.
REQ-004 SHALL have parameter P2_X, default 10'd400, meaning left pixel of player-2 tens field.
REQ-005 SHALL have parameter WIN_SCORE, default 7'd11, meaning binary score that ends the game (1..99).
REQ-006 SHALL have port clk  input  1  system/pixel clock; all logic on rising edge.
REQ-007 SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-008 SHALL have port pixel_x  input  10  current horizontal pixel coordinate.
REQ-009 SHALL have port pixel_y  input  10  current vertical pixel coordinate.
REQ-010 SHALL have port video_on  input  1  high inside the visible area.
REQ-011 SHALL have port frame_tick  input  1  one-cycle pulse per frame.
REQ-012 SHALL have port point_p1 / point_p2  input  1 each  one-cycle point-scored pulses.
REQ-013 SHALL have port restart  input  1  one-cycle game-restart pulse.
REQ-014 SHALL have port glyph_pixel  input  1  combinational pixel returned by the shared 3x5 digit glyph lookup.
REQ-015 SHALL have port glyph_number  output  5  digit code (0-9) presented to the glyph lookup.
REQ-016 SHALL have port glyph_position  output  5  bit index 3*row+col (0-14) presented to the glyph lookup.
REQ-017 SHALL have port score_pixel  output  1  score overlay pixel.
REQ-018 SHALL have port game_over  output  1  high in OVER state.
REQ-019 SHALL have port winner  output  2  2'b01 player 1, 2'b10 player 2, 2'b11 tie, 2'b00 none.

Function
REQ-020 SHALL hold each score as two BCD digits (tens, ones), increment with decimal carry, saturate at 99.
REQ-021 SHALL define four fields, cell = 2^CELL_SHIFT px: P1 tens at P1_X, P1 ones at P1_X+4*cell, P2 tens at P2_X, P2 ones at P2_X+4*cell; each 3 cells wide, 5 cells tall from SCORE_Y.
REQ-022 SHALL compute row=(pixel_y-SCORE_Y)>>CELL_SHIFT, col=(pixel_x-origin)>>CELL_SHIFT; hit only when video_on, row 0-4, col 0-2 (unsigned subtract; underflow is a miss).
REQ-023 SHALL register stage 1 (cycle N+1): glyph_number=selected BCD digit, glyph_position=3*row+col, hit flag; on miss glyph_number=5'd15, glyph_position=0.
REQ-024 SHALL register stage 2 (cycle N+2): score_pixel = glyph_pixel AND stage-1 hit AND blink_visible; total latency 2 cycles from pixel_x/pixel_y.
REQ-025 SHALL implement FSM PLAY->OVER when either score >= WIN_SCORE after update; OVER->PLAY only on restart.
REQ-026 SHALL apply point_p1 and point_p2 in the same cycle both; if both cross WIN_SCORE together, winner=2'b11.
REQ-027 SHALL ignore point pulses in OVER state.
REQ-028 SHALL give restart priority over simultaneous point pulses: scores 00/00, winner 2'b00, state PLAY next cycle.
REQ-029 SHALL leave the displayed digits untouched mid-frame except by the update cycle itself (no double increment for a one-cycle pulse).

Reset
REQ-030 SHALL on reset_n low at a clock edge: scores 00/00, state PLAY, glyph_number 5'd15, glyph_position 0, score_pixel 0, game_over 0, winner 2'b00, blink counter 0.
REQ-031 SHALL discard in-flight pipeline contents on reset; first valid score_pixel appears 2 cycles after reset_n rises.

Configuration
REQ-032 SHALL, with SCORE_BLINK_EN defined, count frame_tick in a 5-bit counter in OVER state and blank the winner's fields (both on tie) while counter bit 4 is 1 (16-frame on/off); counter clears on entering OVER.
REQ-033 SHALL, without SCORE_BLINK_EN, hold blink_visible=1 always and omit the counter.

Verification
REQ-034 SHALL test reset: hold reset_n low 3 cycles with point pulses -> all outputs at reset values, scores 00/00.
REQ-035 SHALL test 10 point_p1 pulses, then pixel (P1_X+8, SCORE_Y) -> glyph_number=1, glyph_position=1 at N+1; score_pixel=glyph_pixel at N+2.
REQ-036 SHALL test point_p1 and point_p2 in the same cycle from 09/09 -> 10/10, no lost carry.
REQ-037 SHALL test P2 reaching 11 -> game_over=1, winner=2'b10; further point pulses leave 11 unchanged.
REQ-038 SHALL test restart with point_p1 in the same cycle -> 00/00, game_over=0.
REQ-039 SHALL test pixel (0,0) or video_on=0 with glyph_pixel forced 1 -> glyph_number=15, score_pixel=0.
